hs_rr_arbiter: RTL and testbench

Round-robin arbiter sharing one ready/valid handshake channel between N requesters. Typical placement is in front of a shared pipeline stage or skid buffer, e.g. two issue sources merging into one execute port. The grant is locked while an offered beat is stalled, so the payload seen downstream never changes before acceptance. An optional output register breaks the ready/valid combinational path.

---
 rtl/hs_pkg.sv | 20 ++
 rtl/hs_rr_pick.sv | 35 +++
 rtl/hs_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_hs_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared helpers for the handshake arbiters: index width, wrap arithmetic
// and the lock-state encoding used by hs_rr_arbiter.
package hs_pkg;

    typedef enum logic {
        ARB_OPEN = 1'b0,
        ARB_HELD = 1'b1
    } lock_e;

    // Index width for N requesters; never below 1 so N=2 still gets a bit.
    function automatic int hs_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Round-robin successor with an explicit wrap, valid for non-power-of-two N.
    function automatic int unsigned hs_rr_next(input int unsigned last, input int unsigned n);
        return (last >= n - 1) ? 0 : last + 1;
    endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of req searching
// last+1, last+2, ... modulo N.
module hs_rr_pick
    import hs_pkg::*;
#(
    parameter  int N     = 2,
    localparam int IDX_W = hs_idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] pick,
    output logic             any
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // NOTE: idx and found are scratch values walked through the loop, so they
    // use blocking assignments and are given a value before the loop starts.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = IDX_W'(hs_rr_next(32'(last), N));
        for (int k = 0; k < N; k++) begin
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = IDX_W'(hs_rr_next(32'(idx), N));
        end
    end

    assign any = |req;

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter merging N ready/valid requesters onto one channel.
// Define HS_ARB_OUTREG_EN to add a one-entry output register after the pick.
module hs_rr_arbiter
    import hs_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int WIDTH = 1,
    localparam int IDX_W = hs_idx_w(N)
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             flush_req,
    input  logic [WIDTH-1:0] in [N],
    input  logic [N-1:0]     valid_i,
    output logic [N-1:0]     ready_o,
    output logic [WIDTH-1:0] out,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [IDX_W-1:0] grant_o
);

    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N - 1);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] rr_pick;
    logic [IDX_W-1:0] pick;
    logic             any_req;

    hs_rr_pick #(.N(N)) u_pick (
        .req  (valid_i),
        .last (last_q),
        .pick (rr_pick),
        .any  (any_req)
    );

`ifdef HS_ARB_OUTREG_EN

    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic [IDX_W-1:0] gidx_q;
    logic             load;

    // The register holds the payload, so the pick never needs locking.
    assign pick = rr_pick;
    assign load = ~full_q | ready_i;

    // NOTE: every bit of ready_o gets a default before the conditional
    // assignment, otherwise the unassigned bits would infer latches.
    always_comb begin
        ready_o = '0;
        if (any_req && load && !flush_req && !rst_core)
            ready_o[pick] = 1'b1;
    end

    // NOTE: state flops take non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            full_q <= 1'b0;
            data_q <= '0;
            gidx_q <= '0;
            last_q <= LAST_RST;
        end else if (flush_req) begin
            full_q <= 1'b0;
            last_q <= LAST_RST;
        end else if (load) begin
            full_q <= any_req;
            if (any_req) begin
                data_q <= in[pick];
                gidx_q <= pick;
                last_q <= pick;
            end
        end
    end

    assign valid_o = full_q;
    assign out     = data_q;
    assign grant_o = gidx_q;

`else

    lock_e            lock_q;
    logic [IDX_W-1:0] lock_idx_q;
    logic [IDX_W-1:0] grant_q;

    assign pick = (lock_q == ARB_HELD) ? lock_idx_q : rr_pick;

    // Reset and flush hide the offer so no beat is presented or consumed.
    assign valid_o = any_req & ~flush_req & ~rst_core;
    assign out     = in[pick];
    assign grant_o = (any_req && !rst_core) ? pick : grant_q;

    always_comb begin
        ready_o = '0;
        if (valid_o && ready_i)
            ready_o[pick] = 1'b1;
    end

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            lock_q     <= ARB_OPEN;
            lock_idx_q <= '0;
            last_q     <= LAST_RST;
            grant_q    <= '0;
        end else begin
            grant_q <= grant_o;
            if (flush_req) begin
                lock_q <= ARB_OPEN;
                last_q <= LAST_RST;
            end else if (valid_o) begin
                if (ready_i) begin
                    last_q <= pick;
                    lock_q <= ARB_OPEN;
                end else begin
                    lock_q     <= ARB_HELD;
                    lock_idx_q <= pick;
                end
            end
        end
    end

`endif

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Bench for hs_rr_arbiter: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the arbitration rules.
module tb_hs_rr_arbiter;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int IW = 2;

    logic          clk_core = 1'b0;
    logic          rst_core;
    logic          flush_req;
    logic [W-1:0]  in_d [N];
    logic [N-1:0]  valid_i;
    logic [N-1:0]  ready_o;
    logic [W-1:0]  out_d;
    logic          valid_o;
    logic          ready_i;
    logic [IW-1:0] grant_o;

    always #5 clk_core = ~clk_core;

    hs_rr_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk_core  (clk_core),
        .rst_core  (rst_core),
        .flush_req (flush_req),
        .in        (in_d),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .out       (out_d),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .grant_o   (grant_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int           m_last, m_locked, m_lock_idx, m_grant;
    int           m_full, m_gidx;
    logic [W-1:0] m_data;
    // Expected outputs for the current cycle
    int           e_pick, e_grant;
    bit           e_any, e_valid;
    logic [N-1:0] e_ready;
    logic [W-1:0] e_out;

    function automatic int rr_search(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return 0;
    endfunction

    task automatic model_reset();
        m_last = N - 1; m_locked = 0; m_lock_idx = 0; m_grant = 0;
        m_full = 0; m_gidx = 0; m_data = '0;
    endtask

    task automatic model_eval();
        e_any   = |valid_i;
        e_ready = '0;
`ifdef HS_ARB_OUTREG_EN
        e_pick  = rr_search(m_last, valid_i);
        e_valid = (m_full != 0);
        e_grant = m_gidx;
        e_out   = m_data;
        if (e_any && (m_full == 0 || ready_i) && !flush_req && !rst_core) e_ready[e_pick] = 1'b1;
`else
        e_pick  = (m_locked != 0) ? m_lock_idx : rr_search(m_last, valid_i);
        e_valid = e_any && !flush_req && !rst_core;
        e_grant = (e_any && !rst_core) ? e_pick : m_grant;
        e_out   = in_d[e_pick];
        if (e_valid && ready_i) e_ready[e_pick] = 1'b1;
`endif
    endtask

    task automatic model_step();
`ifdef HS_ARB_OUTREG_EN
        if (flush_req) begin
            m_full = 0; m_last = N - 1;
        end else if (m_full == 0 || ready_i) begin
            m_full = e_any ? 1 : 0;
            if (e_any) begin
                m_data = in_d[e_pick]; m_gidx = e_pick; m_last = e_pick;
            end
        end
`else
        m_grant = e_grant;
        if (flush_req) begin
            m_locked = 0; m_last = N - 1;
        end else if (e_valid) begin
            if (ready_i) begin
                m_last = e_pick; m_locked = 0;
            end else begin
                m_locked = 1; m_lock_idx = e_pick;
            end
        end
`endif
    endtask

    task automatic settle();
        @(negedge clk_core);
        model_eval();
        check("valid_o", valid_o, e_valid);
        check("ready_o", ready_o, e_ready);
        check("grant_o", grant_o, e_grant);
        if (e_valid) check("out", out_d, e_out);
    endtask

    task automatic tick();
        @(posedge clk_core);
        model_step();
        #1;
    endtask

    // Requesters retire accepted beats and may raise new ones; ready and flush are random.
    task automatic drive_random();
        for (int i = 0; i < N; i++) begin
            if (e_ready[i] && valid_i[i]) valid_i[i] = 1'b0;
            if (!valid_i[i] && $urandom_range(0, 99) < 60) begin
                valid_i[i] = 1'b1;
                in_d[i]    = W'($urandom);
            end
        end
        ready_i   = ($urandom_range(0, 99) < 65);
        flush_req = ($urandom_range(0, 99) < 5);
    endtask

    initial begin
        rst_core  = 1'b1;
        flush_req = 1'b0;
        ready_i   = 1'b0;
        valid_i   = '0;
        for (int i = 0; i < N; i++) in_d[i] = '0;
        model_reset();
        #12;
        check("rst_valid", valid_o, 0);
        check("rst_grant", grant_o, 0);
        check("rst_ready", ready_o, 0);
        @(negedge clk_core);
        rst_core = 1'b0;
        @(posedge clk_core);
        #1;

`ifdef HS_ARB_OUTREG_EN
        // Requester 2 offers a beat; it appears registered one cycle later.
        valid_i   = 3'b100;
        in_d[2]   = 8'h3C;
        ready_i   = 1'b1;
        settle();
        check("oreg_t_valid", valid_o, 0);
        check("oreg_t_ready", ready_o, 3'b100);
        tick();
        valid_i = '0;
        settle();
        check("oreg_valid", valid_o, 1);
        check("oreg_out", out_d, 8'h3C);
        check("oreg_grant", grant_o, 2);
        tick();
        // Continuous traffic against ready toggling 1,0,1
        valid_i = 3'b111;
        in_d[0] = 8'h10; in_d[1] = 8'h20; in_d[2] = 8'h30;
        for (int c = 0; c < 6; c++) begin
            ready_i = (c % 3 != 1);
            settle();
            for (int i = 0; i < N; i++)
                if (e_ready[i]) in_d[i] = in_d[i] + 8'h01;
            tick();
        end
`else
        // Single requester
        valid_i = 3'b010;
        in_d[1] = 8'hA5;
        ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("single_out", out_d, 8'hA5);
            check("single_grant", grant_o, 1);
            check("single_ready", ready_o, 3'b010);
            tick();
        end
        valid_i = '0;
        settle();
        check("idle_grant_hold", grant_o, 1);
        check("idle_valid", valid_o, 0);
        tick();

        // Flush restores the favour to requester 0, then fair rotation
        flush_req = 1'b1;
        settle();
        tick();
        flush_req = 1'b0;
        valid_i = 3'b111;
        in_d[0] = 8'h11; in_d[1] = 8'h22; in_d[2] = 8'h33;
        for (int c = 0; c < 2 * N; c++) begin
            settle();
            check("rotation", grant_o, c % N);
            tick();
        end

        // Lock under stall on requester 0
        ready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            check("stall_grant", grant_o, 0);
            check("stall_out", out_d, 8'h11);
            check("stall_ready", ready_o, 0);
            tick();
        end
        ready_i = 1'b1;
        settle();
        check("stall_accept", ready_o, 3'b001);
        tick();

        // Stall on requester 1, then flush while locked
        ready_i = 1'b0;
        settle();
        check("lock1_grant", grant_o, 1);
        tick();
        ready_i   = 1'b1;
        flush_req = 1'b1;
        settle();
        check("flush_ready", ready_o, 0);
        tick();
        flush_req = 1'b0;
        settle();
        check("post_flush_grant", grant_o, 0);
        tick();

        // Lock on requester 1, then async reset between edges
        ready_i = 1'b0;
        settle();
        check("pre_arst_grant", grant_o, 1);
        tick();
        settle();
        #2;
        rst_core = 1'b1;
        #1;
        check("arst_valid", valid_o, 0);
        check("arst_grant", grant_o, 0);
        check("arst_ready", ready_o, 0);
        model_reset();
        #1;
        rst_core = 1'b0;
        ready_i  = 1'b1;
        model_eval();
        check("arst_unlocked_grant", grant_o, 0);
        tick();
`endif

        // Randomized traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            drive_random();
            settle();
            tick();
        end
        flush_req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
